// File: rtl/qos_pkg.sv
// Shared types and default constants for the qos credit arbiter.
package qos_pkg;

  // Arbiter FSM states. BLOCK is only reachable when the starvation guard is built in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT   = 2'd1,
    BLOCK = 2'd2
  } qos_arb_state_t;

  localparam int unsigned QOS_DEF_NUM_REQ     = 4;
  localparam int unsigned QOS_DEF_CW          = 32;
  localparam int unsigned QOS_DEF_SZW         = 8;
  localparam int unsigned QOS_DEF_INIT_CREDIT = 256;
  localparam int unsigned QOS_DEF_STARVE_LIM  = 4;

endpackage

// File: rtl/qos_rr_pick.sv
// Rotate-priority picker: the first eligible requester at or after ptr wins.
module qos_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win_oh,
  output logic          win_vld
);

  logic [N-1:0]   rot_s;
  logic [N-1:0]   low_s;
  logic [2*N-1:0] back_s;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot_s   = N'({elig, elig} >> ptr);
    low_s   = rot_s & (~rot_s + {{(N-1){1'b0}}, 1'b1});
    back_s  = {{N{1'b0}}, low_s} << ptr;
    win_oh  = back_s[N-1:0] | back_s[2*N-1:N];
    win_vld = |elig;
  end

endmodule

// File: rtl/qos_credit_arb.sv
// Credit-based QoS arbiter: round-robin grant among requesters whose size fits
// the shared credit pool, with debit on grant and saturating credit return.
// Optional starvation guard enabled by defining QOS_STARVE_GUARD_EN.
module qos_credit_arb
  import qos_pkg::*;
#(
  parameter int unsigned NUM_REQ     = QOS_DEF_NUM_REQ,
  parameter int unsigned CW          = QOS_DEF_CW,
  parameter int unsigned SZW         = QOS_DEF_SZW,
  parameter int unsigned INIT_CREDIT = QOS_DEF_INIT_CREDIT,
  parameter int unsigned STARVE_LIM  = QOS_DEF_STARVE_LIM
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*SZW-1:0]     req_size,
  input  logic                       ret_vld,
  input  logic [SZW-1:0]             ret_amt,
  input  logic                       init_load,
  input  logic [CW-1:0]              init_credit,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic [CW-1:0]              avail_credit,
  output logic                       ovf_err,
  output logic                       blocked
);

  localparam int unsigned PW       = $clog2(NUM_REQ);
  localparam logic [CW-1:0] INIT_V = CW'(INIT_CREDIT);
  localparam logic [CW:0] SAT_MAX  = {1'b0, {CW{1'b1}}};

  // Parameter sanity, caught at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("qos_credit_arb: NUM_REQ must be 2..16");
  end
  if (STARVE_LIM < 1) begin : g_bad_lim
    $error("qos_credit_arb: STARVE_LIM must be at least 1");
  end
  if (CW < SZW) begin : g_bad_cw
    $error("qos_credit_arb: CW must be at least SZW");
  end

  qos_arb_state_t     state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]      gnt_id_q, gnt_id_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      avail_q, avail_d;
  logic               ovf_q, ovf_d;
  logic               blocked_q, blocked_d;

  logic [SZW-1:0]     size_s [NUM_REQ];
  logic [NUM_REQ-1:0] elig_s;
  logic [NUM_REQ-1:0] pick_oh_s;
  logic               pick_vld_s;
  logic [SZW-1:0]     debit_s;
  logic [CW:0]        sum_s;

`ifdef QOS_STARVE_GUARD_EN
  localparam int unsigned CNTW  = $clog2(STARVE_LIM + 1);
  localparam logic [CNTW-1:0] LIM_V = CNTW'(STARVE_LIM);
  logic [CNTW-1:0]    byp_q [NUM_REQ];
  logic [CNTW-1:0]    byp_d [NUM_REQ];
  logic [NUM_REQ-1:0] starv_s;
  logic [NUM_REQ-1:0] tgt_oh_s;
  logic               tgt_found_s;
`endif

  // One-hot to index encoder.
  function automatic logic [PW-1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
    logic [PW-1:0] idx;
    idx = {PW{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = idx | (oh[i] ? PW'(i) : {PW{1'b0}});
    end
    return idx;
  endfunction

  // Size of the requester selected by a one-hot vector.
  function automatic logic [SZW-1:0] sel_size(input logic [NUM_REQ-1:0] oh,
                                               input logic [NUM_REQ*SZW-1:0] sizes);
    logic [SZW-1:0] sz;
    sz = {SZW{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sz = sz | (sizes[i*SZW +: SZW] & {SZW{oh[i]}});
    end
    return sz;
  endfunction

  // Round-robin pointer advance: one past the winner, wrapping at NUM_REQ.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    return (idx == PW'(NUM_REQ - 1)) ? {PW{1'b0}} : idx + PW'(1);
  endfunction

  // Unpack sizes and form the eligible set against the current pool.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      size_s[i] = req_size[i*SZW +: SZW];
      elig_s[i] = req[i] && (CW'(size_s[i]) <= avail_q);
    end
  end

  qos_rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .elig    (elig_s),
    .ptr     (rr_ptr_q),
    .win_oh  (pick_oh_s),
    .win_vld (pick_vld_s)
  );

`ifdef QOS_STARVE_GUARD_EN
  // Starved requesters and the lowest-index one among them.
  always_comb begin
    tgt_found_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      starv_s[i]  = req[i] && (byp_q[i] >= LIM_V);
      tgt_oh_s[i] = starv_s[i] && !tgt_found_s;
      tgt_found_s = tgt_found_s || starv_s[i];
    end
  end
`endif

  // Arbiter next-state, grant and pointer logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = {NUM_REQ{1'b0}};
    gnt_id_d  = gnt_id_q;
    rr_ptr_d  = rr_ptr_q;
    debit_s   = {SZW{1'b0}};
    blocked_d = 1'b0;
`ifdef QOS_STARVE_GUARD_EN
    byp_d     = byp_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef QOS_STARVE_GUARD_EN
        if (tgt_found_s) begin
          state_d   = BLOCK;
          blocked_d = 1'b1;
        end else
`endif
        if (pick_vld_s) begin
          state_d  = GNT;
          gnt_d    = pick_oh_s;
          gnt_id_d = oh2idx(pick_oh_s);
          rr_ptr_d = next_ptr(oh2idx(pick_oh_s));
          debit_s  = sel_size(pick_oh_s, req_size);
`ifdef QOS_STARVE_GUARD_EN
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh_s[i]) begin
              byp_d[i] = {CNTW{1'b0}};
            end else if (req[i] && !elig_s[i] && (byp_q[i] < LIM_V)) begin
              byp_d[i] = byp_q[i] + CNTW'(1);
            end else begin
              byp_d[i] = byp_q[i];
            end
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GNT: begin
        state_d = IDLE;
      end
`ifdef QOS_STARVE_GUARD_EN
      BLOCK: begin
        if (!tgt_found_s) begin
          state_d = IDLE;
        end else if (|(tgt_oh_s & elig_s)) begin
          state_d  = GNT;
          gnt_d    = tgt_oh_s;
          gnt_id_d = oh2idx(tgt_oh_s);
          rr_ptr_d = next_ptr(oh2idx(tgt_oh_s));
          debit_s  = sel_size(tgt_oh_s, req_size);
          for (int i = 0; i < NUM_REQ; i++) begin
            byp_d[i] = tgt_oh_s[i] ? {CNTW{1'b0}} : byp_q[i];
          end
        end else begin
          state_d   = BLOCK;
          blocked_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef QOS_STARVE_GUARD_EN
    // A requester that withdraws is no longer being bypassed.
    for (int i = 0; i < NUM_REQ; i++) begin
      byp_d[i] = req[i] ? byp_d[i] : {CNTW{1'b0}};
    end
`endif
  end

  // Credit pool: load wins over debit/return; otherwise debit plus return, saturating.
  always_comb begin
    sum_s = {1'b0, avail_q}
          - {{(CW+1-SZW){1'b0}}, debit_s}
          + (ret_vld ? {{(CW+1-SZW){1'b0}}, ret_amt} : {(CW+1){1'b0}});
    if (init_load) begin
      avail_d = init_credit;
      ovf_d   = ovf_q;
    end else if (sum_s > SAT_MAX) begin
      avail_d = {CW{1'b1}};
      ovf_d   = 1'b1;
    end else begin
      avail_d = sum_s[CW-1:0];
      ovf_d   = ovf_q;
    end
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= {NUM_REQ{1'b0}};
      gnt_id_q  <= {PW{1'b0}};
      rr_ptr_q  <= {PW{1'b0}};
      avail_q   <= INIT_V;
      ovf_q     <= 1'b0;
      blocked_q <= 1'b0;
`ifdef QOS_STARVE_GUARD_EN
      for (int i = 0; i < NUM_REQ; i++) begin
        byp_q[i] <= {CNTW{1'b0}};
      end
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      rr_ptr_q  <= rr_ptr_d;
      avail_q   <= avail_d;
      ovf_q     <= ovf_d;
      blocked_q <= blocked_d;
`ifdef QOS_STARVE_GUARD_EN
      for (int i = 0; i < NUM_REQ; i++) begin
        byp_q[i] <= byp_d[i];
      end
`endif
    end
  end

  assign gnt          = gnt_q;
  assign gnt_id       = gnt_id_q;
  assign avail_credit = avail_q;
  assign ovf_err      = ovf_q;
  assign blocked      = blocked_q;

endmodule

// File: tb/tb_qos_credit_arb.sv
// Directed bench for qos_credit_arb: a table of per-cycle vectors plus
// hand-written multi-cycle sequences (return wake-up, starvation guard).
module tb_qos_credit_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_size;
  logic        ret_vld;
  logic [7:0]  ret_amt;
  logic        init_load;
  logic [31:0] init_credit;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic [31:0] avail_credit;
  logic        ovf_err;
  logic        blocked;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] sz;
    logic        rv;
    logic [7:0]  ra;
    logic        il;
    logic [31:0] ic;
    logic [3:0]  eg;
    logic [1:0]  eid;
    logic [31:0] ea;
    logic        eo;
  } vec_t;

  vec_t tbl[$];

  qos_credit_arb dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_size     (req_size),
    .ret_vld      (ret_vld),
    .ret_amt      (ret_amt),
    .init_load    (init_load),
    .init_credit  (init_credit),
    .gnt          (gnt),
    .gnt_id       (gnt_id),
    .avail_credit (avail_credit),
    .ovf_err      (ovf_err),
    .blocked      (blocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] sz4(input int s3, input int s2, input int s1, input int s0);
    return {8'(s3), 8'(s2), 8'(s1), 8'(s0)};
  endfunction

  task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] sz,
                     input logic rv, input logic [7:0] ra, input logic il,
                     input logic [31:0] ic, input logic [3:0] eg, input logic [1:0] eid,
                     input logic [31:0] ea, input logic eo);
    vec_t v;
    v.rst = r; v.req = rq; v.sz = sz; v.rv = rv; v.ra = ra; v.il = il; v.ic = ic;
    v.eg = eg; v.eid = eid; v.ea = ea; v.eo = eo;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int  cyc;
  bit  got;

  initial begin
    // rst rq    sizes               rv ra   il ic            eg     id ea            eo
    add(0, 4'b0001, sz4(0,0,0,16),  0, 0,   0, 0,            4'b0001, 0, 240,          0);
    add(0, 4'b0000, sz4(0,0,0,16),  0, 0,   0, 0,            4'b0000, 0, 240,          0);
    add(1, 4'b0000, sz4(0,0,0,0),   0, 0,   0, 0,            4'b0000, 0, 256,          0);
    add(0, 4'b1111, sz4(8,8,8,8),   0, 0,   0, 0,            4'b0001, 0, 248,          0);
    add(0, 4'b1110, sz4(8,8,8,8),   0, 0,   0, 0,            4'b0000, 0, 248,          0);
    add(0, 4'b1110, sz4(8,8,8,8),   0, 0,   0, 0,            4'b0010, 1, 240,          0);
    add(0, 4'b1100, sz4(8,8,8,8),   0, 0,   0, 0,            4'b0000, 0, 240,          0);
    add(0, 4'b1100, sz4(8,8,8,8),   0, 0,   0, 0,            4'b0100, 2, 232,          0);
    add(0, 4'b1000, sz4(8,8,8,8),   0, 0,   0, 0,            4'b0000, 0, 232,          0);
    add(0, 4'b1001, sz4(8,8,8,8),   0, 0,   0, 0,            4'b1000, 3, 224,          0);
    add(0, 4'b0001, sz4(8,8,8,8),   0, 0,   0, 0,            4'b0000, 0, 224,          0);
    add(0, 4'b0001, sz4(8,8,8,8),   0, 0,   0, 0,            4'b0001, 0, 216,          0);
    add(0, 4'b0000, sz4(0,0,0,0),   0, 0,   0, 0,            4'b0000, 0, 216,          0);
    add(0, 4'b0000, sz4(0,0,0,0),   0, 0,   1, 10,           4'b0000, 0, 10,           0);
    add(0, 4'b0001, sz4(0,0,0,20),  1, 12,  0, 0,            4'b0000, 0, 22,           0);
    add(0, 4'b0001, sz4(0,0,0,20),  0, 0,   0, 0,            4'b0001, 0, 2,            0);
    add(0, 4'b0000, sz4(0,0,0,0),   0, 0,   0, 0,            4'b0000, 0, 2,            0);
    add(0, 4'b0000, sz4(0,0,0,0),   0, 0,   1, 100,          4'b0000, 0, 100,          0);
    add(0, 4'b0010, sz4(0,0,16,0),  1, 16,  0, 0,            4'b0010, 1, 100,          0);
    add(0, 4'b0000, sz4(0,0,0,0),   0, 0,   0, 0,            4'b0000, 0, 100,          0);
    add(0, 4'b0000, sz4(0,0,0,0),   1, 30,  1, 50,           4'b0000, 0, 50,           0);
    add(0, 4'b0000, sz4(0,0,0,0),   0, 0,   1, 0,            4'b0000, 0, 0,            0);
    add(0, 4'b0100, sz4(0,0,0,0),   0, 0,   0, 0,            4'b0100, 2, 0,            0);
    add(0, 4'b0000, sz4(0,0,0,0),   0, 0,   0, 0,            4'b0000, 0, 0,            0);
    add(0, 4'b0011, sz4(0,0,0,5),   0, 0,   0, 0,            4'b0010, 1, 0,            0);
    add(0, 4'b0001, sz4(0,0,0,5),   0, 0,   0, 0,            4'b0000, 0, 0,            0);
    add(0, 4'b0001, sz4(0,0,0,5),   0, 0,   0, 0,            4'b0000, 0, 0,            0);
    add(0, 4'b0000, sz4(0,0,0,0),   0, 0,   0, 0,            4'b0000, 0, 0,            0);
    add(0, 4'b0000, sz4(0,0,0,0),   0, 0,   1, 32'hFFFF_FFFB, 4'b0000, 0, 32'hFFFF_FFFB, 0);
    add(0, 4'b0000, sz4(0,0,0,0),   1, 10,  0, 0,            4'b0000, 0, 32'hFFFF_FFFF, 1);
    add(0, 4'b0001, sz4(0,0,0,16),  0, 0,   0, 0,            4'b0001, 0, 32'hFFFF_FFEF, 1);
    add(0, 4'b0000, sz4(0,0,0,0),   0, 0,   0, 0,            4'b0000, 0, 32'hFFFF_FFEF, 1);
    add(0, 4'b0000, sz4(0,0,0,0),   1, 16,  0, 0,            4'b0000, 0, 32'hFFFF_FFFF, 1);
    add(0, 4'b0000, sz4(0,0,0,0),   0, 0,   1, 256,          4'b0000, 0, 256,          1);
    add(0, 4'b0001, sz4(0,0,0,16),  0, 0,   0, 0,            4'b0001, 0, 240,          1);
    add(1, 4'b0000, sz4(0,0,0,0),   0, 0,   0, 0,            4'b0000, 0, 256,          0);
    add(0, 4'b0011, sz4(0,0,8,8),   0, 0,   0, 0,            4'b0001, 0, 248,          0);
    add(0, 4'b0010, sz4(0,0,8,8),   0, 0,   0, 0,            4'b0000, 0, 248,          0);
    add(0, 4'b0010, sz4(0,0,8,8),   0, 0,   0, 0,            4'b0010, 1, 240,          0);
    add(0, 4'b0000, sz4(0,0,0,0),   0, 0,   0, 0,            4'b0000, 0, 240,          0);

    rst = 1'b1; req = 4'b0; req_size = 32'd0; ret_vld = 1'b0; ret_amt = 8'd0;
    init_load = 1'b0; init_credit = 32'd0;
    repeat (2) tick();
    chk("reset gnt", gnt, 4'b0000);
    chk("reset gnt_id", gnt_id, 2'd0);
    chk("reset avail", avail_credit, 32'd256);
    chk("reset ovf", ovf_err, 1'b0);
    chk("reset blocked", blocked, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; req = tbl[i].req; req_size = tbl[i].sz;
      ret_vld = tbl[i].rv; ret_amt = tbl[i].ra;
      init_load = tbl[i].il; init_credit = tbl[i].ic;
      tick();
      chk($sformatf("row%0d gnt", i), gnt, tbl[i].eg);
      if (tbl[i].eg != 4'b0000) chk($sformatf("row%0d gnt_id", i), gnt_id, tbl[i].eid);
      chk($sformatf("row%0d avail", i), avail_credit, tbl[i].ea);
      chk($sformatf("row%0d ovf", i), ovf_err, tbl[i].eo);
      chk($sformatf("row%0d blocked", i), blocked, 1'b0);
    end
    rst = 1'b0; ret_vld = 1'b0; init_load = 1'b0; req = 4'b0;

    // Return-driven wake-up: empty pool, three returns of 10 feed a size-30 request.
    init_load = 1'b1; init_credit = 32'd0;
    tick();
    init_load = 1'b0;
    req = 4'b0100; req_size = sz4(0,30,0,0); ret_vld = 1'b1; ret_amt = 8'd10;
    got = 1'b0; cyc = 0;
    while (!got && cyc < 10) begin
      tick();
      cyc++;
      if (cyc == 3) ret_vld = 1'b0;
      if (gnt != 4'b0000) got = 1'b1;
    end
    ret_vld = 1'b0;
    chk("wake cycle", cyc, 4);
    chk("wake gnt", gnt, 4'b0100);
    chk("wake avail", avail_credit, 32'd0);
    req = 4'b0000;
    tick();
    chk("wake gnt pulse", gnt, 4'b0000);

`ifdef QOS_STARVE_GUARD_EN
    // Large request on 0 bypassed by small ones on 1 until the guard blocks.
    rst = 1'b1; tick(); rst = 1'b0;
    init_load = 1'b1; init_credit = 32'd100; tick(); init_load = 1'b0;
    req_size = sz4(0,0,8,200);
    for (int k = 0; k < 4; k++) begin
      req = 4'b0011; tick();
      chk($sformatf("starve byp%0d gnt", k), gnt, 4'b0010);
      req = 4'b0001; tick();
      chk($sformatf("starve byp%0d idle", k), gnt, 4'b0000);
    end
    req = 4'b0011; tick();
    chk("starve enter blocked", blocked, 1'b1);
    chk("starve enter gnt", gnt, 4'b0000);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("starve hold%0d gnt", k), gnt, 4'b0000);
      chk($sformatf("starve hold%0d blocked", k), blocked, 1'b1);
    end
    chk("starve pool", avail_credit, 32'd68);
    ret_vld = 1'b1; ret_amt = 8'd132; tick(); ret_vld = 1'b0;
    chk("starve refill", avail_credit, 32'd200);
    chk("starve refill blocked", blocked, 1'b1);
    tick();
    chk("starve release gnt", gnt, 4'b0001);
    chk("starve release blocked", blocked, 1'b0);
    chk("starve release avail", avail_credit, 32'd0);
    req = 4'b0010; tick();
    chk("starve after blocked", blocked, 1'b0);
    req = 4'b0000;
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/qos_credit_arb.md
# qos_credit_arb

Credit-based QoS arbiter for the qos datapath: owns the shared `avail_credit` pool and grants one of `NUM_REQ` requesters per grant cycle when its requested transfer size fits in the pool. It runs round-robin among eligible requesters, debits granted sizes, and credits returns. An optional starvation guard stops a large request from being bypassed forever by smaller ones.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `CW`, 32: credit width; matches the `avail_credit` width.
- `SZW`, 8: width of request size and return amount.
- `INIT_CREDIT`, 256: pool value loaded at reset.
- `STARVE_LIM`, 4: consecutive bypasses before the guard blocks; used only with the macro.
- `clk` input 1: clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input `NUM_REQ`: per-requester request level. Held until granted.
- `req_size` input `NUM_REQ*SZW`: flat size vector. Slice i belongs to `req[i]`. Stable while `req[i]` is high.
- `ret_vld` input 1: credit return strobe.
- `ret_amt` input `SZW`: credits returned when `ret_vld` is high.
- `init_load` input 1: overwrite the pool with `init_credit`.
- `init_credit` input `CW`: load value.
- `gnt` output `NUM_REQ`: one-hot grant, one cycle wide.
- `gnt_id` output `$clog2(NUM_REQ)`: index of the granted requester, valid when `gnt` is nonzero.
- `avail_credit` output `CW`: current pool value, registered.
- `ovf_err` output 1: sticky flag, set when a return saturates the pool.
- `blocked` output 1: high while the starvation guard holds grants; always 0 without the macro.

## Operation
- State machine states: IDLE, GNT, BLOCK.
- IDLE:
  - Eligible set = {i : `req[i]` and `req_size[i]` ≤ `avail_credit`}.
  - Round-robin search starts at `rr_ptr`.
  - If the set is nonempty: register the winner, go to GNT.
- GNT:
  - `gnt[w]` is high for exactly this cycle.
  - `avail_credit` is debited at the edge that enters GNT, so the debit is visible in the GNT cycle.
  - `rr_ptr` becomes w+1 mod `NUM_REQ`.
  - Requests are ignored in this cycle; the requester drops `req[w]` in the GNT cycle.
  - Returns to IDLE.
- Pool update per edge, in priority order:
  - `rst` loads `INIT_CREDIT`.
  - Otherwise `init_load` loads `init_credit`; a simultaneous debit and return are discarded.
  - Otherwise next = avail − debit + (`ret_vld` ? `ret_amt` : 0).
  - Computed at CW+1 bits and saturated at 2^CW−1. Saturation sets `ovf_err`.
  - Debit can never underflow, because grants require size ≤ avail.
- A size-0 request is always eligible and debits 0.
- A return in the same cycle as a debit is applied in full; no ordering loss.
- Reset mid-grant: `gnt` is 0 on the next cycle, the debit is discarded, and the pool is `INIT_CREDIT`.
- Reset values: `gnt`=0, `gnt_id`=0, `avail_credit`=`INIT_CREDIT`, `ovf_err`=0, `blocked`=0, `rr_ptr`=0, state IDLE, all bypass counters 0.

## Timing
- Grant latency: `req` high at edge N with sufficient credit gives `gnt` in cycle N+1. Minimum 2-cycle spacing between grants.
- `avail_credit` reflects a return on the cycle after `ret_vld`.
- Maximum throughput: one grant every 2 cycles.
- No combinational path from inputs to outputs.

## Configuration
- `QOS_STARVE_GUARD_EN` defined:
  - Each requester has a bypass counter, incremented when it requests but is ineligible while another requester is granted.
  - The counter clears when that requester is granted.
  - When a counter reaches `STARVE_LIM`, the FSM enters BLOCK with `blocked`=1.
  - In BLOCK, all grants are withheld until the starved request fits. It is then granted (BLOCK→GNT) and `blocked` drops.
  - If the starved requester drops `req`, the FSM returns to IDLE.
  - The lowest-index starved requester wins.
- `QOS_STARVE_GUARD_EN` undefined: no counters and no BLOCK state; `blocked` is tied to 0.

## Structure
- Shared package `qos_pkg`: state enum `qos_arb_state_t` (IDLE/GNT/BLOCK) and the default credit constants.
- One sub-module, `qos_rr_pick`: combinational rotate-priority picker. Inputs are the eligible vector and `rr_ptr`; outputs are the one-hot winner and a valid flag.

## Test plan
- Reset then `req`=4'b0001, size 16 → `gnt`=0001 next cycle, `avail_credit` 256→240.
- All four requesting, size 8 each → grants in order 0,1,2,3,0 on alternate cycles; pool drops by 8 per grant.
- Pool 10, `req[0]` size 20, `ret_vld` with `ret_amt`=12 → no grant until the pool reads 22, then grant 0; pool goes 22→2.
- `init_load`=1 with `init_credit`=2^32−5, then return 10 → `avail_credit`=2^32−1 and `ovf_err`=1 (sticky through further traffic).
- Debit 16 and return 16 in the same edge → pool unchanged; `rst` asserted in the GNT cycle → `gnt`=0 and pool 256 next cycle.
- With the macro, `STARVE_LIM`=4: `req[0]` size 200 and `req[1]` size 8 looping, pool 100 → after 4 bypasses `blocked`=1 and `req[1]` is held off. Returns raise the pool to 200 → `gnt[0]`, then `blocked`=0.
